// File: rtl/cdce_serial_in.sv
// Readback receiver for the CDCE SPI link: frames one read with cs_n, samples miso,
// presents the captured word and flags masked mismatches against an expected value.
module cdce_serial_in #(
  parameter int WORD_WIDTH = 32,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 1,
  parameter int CS_GAP     = 2,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  start_transaction,
  input  logic [WORD_WIDTH-1:0] expected_data,
  input  logic [WORD_WIDTH-1:0] compare_mask,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  mosi,
  output logic [WORD_WIDTH-1:0] parallel_output,
  output logic                  data_valid,
  output logic                  mismatch,
  output logic [7:0]            mismatch_count,
  output logic                  transaction_done
);

  localparam int MAX_SG  = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int MAX_HW  = (CS_HOLD > WORD_WIDTH) ? CS_HOLD : WORD_WIDTH;
  localparam int CNT_MAX = (MAX_SG > MAX_HW) ? MAX_SG : MAX_HW;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [WORD_WIDTH-1:0] sr_reg;
  logic [WORD_WIDTH-1:0] exp_reg;
  logic [WORD_WIDTH-1:0] mask_reg;
  logic [WORD_WIDTH-1:0] sr_next;
  logic                  mismatch_next;

  // Bit order of the incoming stream decides which end of the shift register fills first.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_next = {sr_reg[WORD_WIDTH-2:0], miso};
    end else begin : g_lsb_first
      assign sr_next = {miso, sr_reg[WORD_WIDTH-1:1]};
    end
  endgenerate

  assign mismatch_next = |((sr_reg ^ exp_reg) & mask_reg);
  assign mosi          = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      sr_reg           <= '0;
      exp_reg          <= '0;
      mask_reg         <= '0;
      cs_n             <= 1'b1;
      parallel_output  <= '0;
      data_valid       <= 1'b0;
      mismatch         <= 1'b0;
      mismatch_count   <= 8'd0;
      transaction_done <= 1'b1;
    end else begin
      data_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_transaction && enable) begin
            exp_reg          <= expected_data;
            mask_reg         <= compare_mask;
            transaction_done <= 1'b0;
            cs_n             <= 1'b0;
            cnt_reg          <= CNT_W'(CS_SETUP - 1);
            state_reg        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_reg == '0) begin
            cnt_reg   <= CNT_W'(WORD_WIDTH - 1);
            state_reg <= ST_SHIFT;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_SHIFT: begin
          sr_reg <= sr_next;
          if (cnt_reg == '0) begin
            cnt_reg   <= CNT_W'(CS_HOLD - 1);
            state_reg <= ST_HOLD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_HOLD: begin
          // First HOLD edge is the one right after the last sample: capture here.
          if (cnt_reg == CNT_W'(CS_HOLD - 1)) begin
            parallel_output <= sr_reg;
            mismatch        <= mismatch_next;
            data_valid      <= 1'b1;
            if (mismatch_next && mismatch_count != 8'hFF)
              mismatch_count <= mismatch_count + 8'd1;
          end
          if (cnt_reg == '0) begin
            cs_n      <= 1'b1;
            cnt_reg   <= CNT_W'(CS_GAP);
            state_reg <= ST_GAP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_reg == '0) begin
            transaction_done <= 1'b1;
            state_reg        <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          cs_n             <= 1'b1;
          transaction_done <= 1'b1;
          state_reg        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
